// File: rtl/ascii_num_sep_pkg.sv
// Shared types and character constants for the ascii_num_sep path.
// The validator and the parser both use is_digit so they agree on what a digit is.
package ascii_num_sep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE,
    ERROR
  } parser_state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_NINE  = 8'h39;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_ZERO) && (c <= CH_NINE);
  endfunction

endpackage

// File: rtl/dec_accumulator.sv
// Decimal magnitude accumulator with sign flag and per-digit overflow detection.
// The magnitude carries one extra bit so -2^(DATA_WIDTH-1) is representable.
module dec_accumulator
  import ascii_num_sep_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         digit_strobe,
  input  logic [3:0]                   digit,
  input  logic                         set_neg,
  output logic signed [DATA_WIDTH-1:0] value,
  output logic                         neg,
  output logic                         overflow
);

  localparam int AW = DATA_WIDTH + 1;
  localparam int WW = DATA_WIDTH + 5;

  logic [AW-1:0] acc;
  logic [WW-1:0] next_mag;
  logic [WW-1:0] limit;

  // The limit depends on the sign already latched at token start.
  always_comb begin
    next_mag = ({4'b0000, acc} * WW'(10)) + WW'(digit);
    limit    = neg ? (WW'(1) << (DATA_WIDTH - 1))
                   : ((WW'(1) << (DATA_WIDTH - 1)) - WW'(1));
    overflow = next_mag > limit;
  end

  assign value = neg ? (DATA_WIDTH'(0) - acc[DATA_WIDTH-1:0]) : acc[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      neg <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      neg <= 1'b0;
    end else begin
      if (digit_strobe && !overflow) acc <= next_mag[AW-1:0];
      if (set_neg) neg <= 1'b1;
    end
  end

endmodule

// File: rtl/ascii_num_parser.sv
// Walks a validated character buffer and streams space-separated signed decimals
// as two's-complement integers over a valid/ready handshake.
module ascii_num_parser
  import ascii_num_sep_pkg::*;
#(
  parameter int MAX_PAYLOAD = 2048,
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic [15:0]                  buffer_length,
  output logic [15:0]                  rd_addr,
  input  logic [7:0]                   rd_data,
  output logic signed [DATA_WIDTH-1:0] num_data,
  output logic                         num_valid,
  input  logic                         num_ready,
  output logic [CNT_WIDTH-1:0]         num_count,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  parser_state_t state;
  logic in_tok, has_digit, final_tok;

  logic acc_clear, digit_strobe, set_neg, acc_overflow;
  logic signed [DATA_WIDTH-1:0] acc_value;

  logic at_end, ch_space, ch_minus, ch_digit;
  logic scan_adv, scan_emit, scan_finish, scan_err;

  dec_accumulator #(.DATA_WIDTH(DATA_WIDTH)) u_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (acc_clear),
    .digit_strobe (digit_strobe),
    .digit        (rd_data[3:0]),
    .set_neg      (set_neg),
    .value        (acc_value),
    .neg          (),
    .overflow     (acc_overflow)
  );

  assign at_end   = (rd_addr == buffer_length) || (32'(rd_addr) >= 32'(MAX_PAYLOAD));
  assign ch_space = rd_data == CH_SPACE;
  assign ch_minus = rd_data == CH_MINUS;
  assign ch_digit = is_digit(rd_data);

  // Decode of one SCAN step; a token of only "-" is rejected when it terminates.
  always_comb begin
    scan_adv     = 1'b0;
    scan_emit    = 1'b0;
    scan_finish  = 1'b0;
    scan_err     = 1'b0;
    digit_strobe = 1'b0;
    set_neg      = 1'b0;
    if (state == SCAN) begin
      if (at_end || ch_space) begin
        if (in_tok) begin
          scan_emit = has_digit;
          scan_err  = !has_digit;
        end else if (at_end) begin
          scan_finish = 1'b1;
        end else begin
          scan_adv = 1'b1;
        end
      end else if (ch_minus) begin
        scan_err = in_tok;
        scan_adv = !in_tok;
        set_neg  = !in_tok;
      end else if (ch_digit) begin
        digit_strobe = 1'b1;
        scan_err     = acc_overflow;
        scan_adv     = !acc_overflow;
      end else begin
        scan_err = 1'b1;
      end
    end
  end

  assign acc_clear = clear || (state == IDLE && start) || (state == EMIT && num_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      num_data  <= '0;
      num_valid <= 1'b0;
      num_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      in_tok    <= 1'b0;
      has_digit <= 1'b0;
      final_tok <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      rd_addr   <= '0;
      num_data  <= '0;
      num_valid <= 1'b0;
      num_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      in_tok    <= 1'b0;
      has_digit <= 1'b0;
      final_tok <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          rd_addr   <= '0;
          num_count <= '0;
          in_tok    <= 1'b0;
          has_digit <= 1'b0;
          busy      <= 1'b1;
          state     <= SCAN;
        end
        SCAN: begin
          if (scan_adv) begin
            rd_addr <= rd_addr + 16'd1;
            if (!ch_space) in_tok <= 1'b1;
            if (ch_digit) has_digit <= 1'b1;
          end
          if (scan_emit) begin
            num_data  <= acc_value;
            num_valid <= 1'b1;
            final_tok <= at_end;
            state     <= EMIT;
          end
          if (scan_finish) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
          if (scan_err) begin
            busy      <= 1'b0;
            error     <= 1'b1;
            num_valid <= 1'b0;
            state     <= ERROR;
          end
        end
        EMIT: if (num_ready) begin
          num_valid <= 1'b0;
          if (num_count != {CNT_WIDTH{1'b1}}) num_count <= num_count + CNT_WIDTH'(1);
          in_tok    <= 1'b0;
          has_digit <= 1'b0;
          if (final_tok) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            rd_addr <= rd_addr + 16'd1;
            state   <= SCAN;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_num_parser.sv
// Scoreboard bench for ascii_num_parser: directed buffers, queued expected numbers,
// and an independent monitor that checks every accepted or stalled output.
module tb_ascii_num_parser;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic [15:0] buffer_length;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic [31:0] num_data;
  logic        num_valid;
  logic        num_ready;
  logic [15:0] num_count;
  logic        busy;
  logic        done;
  logic        error;

  logic [7:0]  mem [0:63];
  logic [31:0] exp_q[$];
  int total;
  int bad;

  ascii_num_parser #(
    .MAX_PAYLOAD (2048),
    .DATA_WIDTH  (32),
    .CNT_WIDTH   (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .clear         (clear),
    .buffer_length (buffer_length),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .num_data      (num_data),
    .num_valid     (num_valid),
    .num_ready     (num_ready),
    .num_count     (num_count),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd_data = (rd_addr < 16'd64) ? mem[rd_addr[5:0]] : 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted word must match the queue head; stalled words must already match it.
  always @(negedge clk) begin
    if (rst_n && num_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_num: got 0x%08h expected no output", num_data);
      end else if (num_ready) begin
        checkOutput("num_data", num_data, exp_q.pop_front());
      end else begin
        checkOutput("stall_data", num_data, exp_q[0]);
      end
    end
  end

  task automatic loadBuffer(input string s);
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    for (int i = 0; i < s.len(); i++) mem[i] = s[i];
    buffer_length = 16'(s.len());
  endtask

  task automatic applyStimulus(input string s, input int ready_low);
    int low_cnt;
    int cyc;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    loadBuffer(s);
    num_ready = (ready_low == 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    low_cnt = 0;
    cyc = 0;
    while (!(done || error) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (!num_ready && num_valid) begin
        low_cnt++;
        if (low_cnt >= ready_low) num_ready = 1'b1;
      end
    end
    if (!(done || error)) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout: got no done/error after %0d cycles expected completion", cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic checkEnd(input string tag, input logic exp_done, input logic exp_err, input int exp_cnt);
    checkOutput({tag, "_done"}, 32'(done), 32'(exp_done));
    checkOutput({tag, "_error"}, 32'(error), 32'(exp_err));
    checkOutput({tag, "_count"}, 32'(num_count), 32'(exp_cnt));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    num_ready = 1'b0;
    loadBuffer("");
    #23;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("rst_num_data", num_data, 32'd0);
    checkOutput("rst_num_valid", 32'(num_valid), 32'd0);
    checkOutput("rst_num_count", 32'(num_count), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);

    exp_q.push_back(32'd12); exp_q.push_back(32'hFFFF_FFF9); exp_q.push_back(32'd0);
    applyStimulus("12 -7 0", 0);
    checkEnd("basic", 1'b1, 1'b0, 3);

    exp_q.push_back(32'd5); exp_q.push_back(32'hFFFF_FFE2);
    applyStimulus("  5   -30  ", 0);
    checkEnd("spaces", 1'b1, 1'b0, 2);

    exp_q.push_back(32'h7FFF_FFFF); exp_q.push_back(32'h8000_0000);
    applyStimulus("2147483647 -2147483648", 0);
    checkEnd("extremes", 1'b1, 1'b0, 2);

    applyStimulus("2147483648", 0);
    checkEnd("overflow", 1'b0, 1'b1, 0);

    exp_q.push_back(32'd5);
    applyStimulus("5 -2147483649", 0);
    checkEnd("neg_overflow", 1'b0, 1'b1, 1);

    applyStimulus("3-4", 0);
    checkEnd("minus_in_tok", 1'b0, 1'b1, 0);

    applyStimulus("- 5", 0);
    checkEnd("lone_minus", 1'b0, 1'b1, 0);

    applyStimulus("", 0);
    checkEnd("empty", 1'b1, 1'b0, 0);

    exp_q.push_back(32'd8); exp_q.push_back(32'd9);
    applyStimulus("8 9", 5);
    checkEnd("backpressure", 1'b1, 1'b0, 2);

    // Second run of "8 9", aborted by clear while still scanning the first token.
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    num_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_scan_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checkOutput("clr_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("clr_num_data", num_data, 32'd0);
    checkOutput("clr_num_valid", 32'(num_valid), 32'd0);
    checkOutput("clr_num_count", 32'(num_count), 32'd0);
    checkOutput("clr_busy", 32'(busy), 32'd0);
    checkOutput("clr_done", 32'(done), 32'd0);
    checkOutput("clr_error", 32'(error), 32'd0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascii_num_parser.md
Name: ascii_num_parser

Overview:
- Downstream stage of the ASCII validator in the ascii_num_sep path.
- Once the validator reports done with no invalid characters, this block walks the validated character buffer. It splits the buffer into space-separated signed decimal tokens and emits each token as a two's-complement integer on a valid/ready stream.
- The matrix-input logic consumes that stream. The block also reports the number count and any syntax or overflow error.

Parameters:
- MAX_PAYLOAD, 2048, depth of the character buffer being read.
- DATA_WIDTH, 32, width of each emitted signed integer.
- CNT_WIDTH, 16, width of the emitted-number counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begin parsing (driven from validator done && !invalid).
- clear  input  1  synchronous abort; return to IDLE.
- buffer_length  input  16  number of valid chars in the buffer.
- rd_addr  output  16  character read address.
- rd_data  input  8  char_buffer[rd_addr], combinational (same-cycle).
- num_data  output  DATA_WIDTH  signed parsed value.
- num_valid  output  1  num_data valid.
- num_ready  input  1  consumer accepts num_data.
- num_count  output  CNT_WIDTH  numbers emitted so far.
- busy  output  1  parsing in progress.
- done  output  1  parse finished cleanly (level, held).
- error  output  1  parse aborted (level, held).

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). All state is cleared on rst_n low.
- Reset values: rd_addr=0, num_data=0, num_valid=0, num_count=0, busy=0, done=0, error=0. Internal acc=0, neg=0, in_tok=0.
- clear has priority over everything except reset. It forces the reset values synchronously from any state.
- States: IDLE, SCAN, EMIT, DONE, ERROR.
- IDLE: on start, set rd_addr=0, num_count=0, acc=0, neg=0, in_tok=0, and go to SCAN. start is ignored outside IDLE.
- SCAN: one char per cycle, ch=rd_data, ptr=rd_addr.
  - ptr==buffer_length (end reached): if in_tok, go to EMIT with final=1. Else go to DONE.
  - ch==0x20 (space): if in_tok, go to EMIT with final=0. Else ptr++ (runs of spaces are collapsed).
  - ch==0x2D (minus): only legal when !in_tok; sets neg=1 and in_tok=1, ptr++. A minus inside a token goes to ERROR.
  - ch is a digit: acc=acc*10+(ch-0x30), in_tok=1, ptr++.
  - Any other char goes to ERROR (defensive; the validator already filters these).
- Token checks:
  - A token consisting only of "-" goes to ERROR when it terminates.
  - Overflow: magnitude held in DATA_WIDTH+1 bits. If acc exceeds 2^(DATA_WIDTH-1)-1 (positive) or 2^(DATA_WIDTH-1) (negative), go to ERROR on the cycle the offending digit is consumed. Because the sign is only known at token start, the check uses the current neg flag.
- EMIT:
  - num_data = neg ? -acc : acc, registered. num_valid=1 and held until num_ready is sampled high.
  - On the accept cycle: num_count++, acc=0, neg=0, in_tok=0, num_valid=0.
  - Then if final, go to DONE. Else ptr++ (skip the terminating space) and go to SCAN.
  - num_data stays stable while num_valid && !num_ready.
- Latency: first num_valid appears no earlier than 1 + (token length + 1) cycles after start. Throughput is one char per cycle plus one cycle per emitted number.
- DONE: done=1, busy=0, num_count held. Exit only via clear or reset.
- ERROR: error=1, busy=0, num_valid=0, num_count = numbers already emitted. Exit only via clear or reset.
- busy=1 in SCAN and EMIT.
- buffer_length=0 at start: go straight to DONE with num_count=0.
- Leading and trailing spaces are ignored.
- num_count saturates at all-ones; it never wraps.

Decomposition:
- Package ascii_num_sep_pkg holds:
  - parser_state_t enum.
  - Character constants CH_SPACE=8'h20, CH_MINUS=8'h2D, CH_ZERO=8'h30, CH_NINE=8'h39.
  - An is_digit function, shared with the validator.
- Sub-module dec_accumulator (natural split) owns acc, neg and the overflow flag. Inputs: load/clear, a digit strobe, a 4-bit digit and a set_neg strobe. It outputs the signed value and an overflow flag combinationally for the current digit.
- The FSM, address pointer and stream handshake stay in ascii_num_parser.

Test Plan:
- Buffer "12 -7 0", length 7, num_ready tied 1 -> emits 12, -7, 0 in order; num_count=3; done=1; error=0.
- Buffer "  5   -30  ", length 11 -> emits 5, -30; num_count=2; done=1.
- Buffer "2147483647 -2147483648" with DATA_WIDTH=32 -> emits 0x7FFFFFFF, 0x80000000; done=1.
- Buffer "2147483648" -> no emission; error=1 on the 10th digit; num_count=0.
- Malformed inputs:
  - "3-4" -> emits nothing, error=1.
  - "- 5" -> error=1, num_count=0.
  - "" (length 0) -> done=1, num_count=0.
- Backpressure on "8 9": num_ready held low 5 cycles -> num_data=8 and num_valid stable throughout; both values delivered; then assert clear mid-SCAN on a second run -> all outputs back to reset values next cycle.
